// File: rtl/fault_inject_if.sv
// Host / frame-BRAM / ICAP signal bundle for the single-bit fault injection controller.
// The slave modport is the controller's view; the master modport is the environment
// (host register bank, frame BRAM and ICAP write-back engine).
interface fault_inject_if;
    logic        start;
    logic [11:0] bit_location;
    logic        busy;
    logic        done;
    logic        err;
    logic        bram_en;
    logic        bram_we;
    logic [12:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
    logic        icap_start;
    logic        icap_done;
    logic [31:0] flip_word;

    modport master (
        output start, bit_location, bram_rdata, icap_done,
        input  busy, done, err, bram_en, bram_we, bram_addr, bram_wdata,
               icap_start, flip_word
    );

    modport slave (
        input  start, bit_location, bram_rdata, icap_done,
        output busy, done, err, bram_en, bram_we, bram_addr, bram_wdata,
               icap_start, flip_word
    );
endinterface

// File: rtl/fault_inject_ctrl.sv
// Single-bit configuration upset sequencer.
// Per accepted start: read the target frame word from the frame BRAM, flip one bit,
// write it back, pulse the ICAP write-back engine and wait (bounded) for its completion.
// Optional build macro FI_VERIFY_EN: re-read the written word and compare it with the
// intended value before starting the ICAP engine; a mismatch ends the request with err.
// All outputs are registered and decoded from the next state.
module fault_inject_ctrl #(
    parameter int BASE_ADDR   = 105,
    parameter int FRAME_WORDS = 101,
    parameter int RD_LAT      = 1,
    parameter int ICAP_TMO    = 4096
) (
    input  logic           clk,
    input  logic           rst,
    fault_inject_if.slave  bus
);

    localparam int                TMO_W    = $clog2(ICAP_TMO + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ICAP_TMO - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [1:0]        LAT_C    = 2'(RD_LAT);
    localparam logic [7:0]        FW_C     = 8'(FRAME_WORDS);
    localparam logic [12:0]       BASE_C   = 13'(BASE_ADDR);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK     = 4'd1,
        ST_RD        = 4'd2,
        ST_WAIT      = 4'd3,
        ST_MOD       = 4'd4,
        ST_WR        = 4'd5,
        ST_VRD       = 4'd6,
        ST_VWAIT     = 4'd7,
        ST_VCMP      = 4'd8,
        ST_ICAP      = 4'd9,
        ST_WAIT_ICAP = 4'd10,
        ST_DONE      = 4'd11
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               err_set_s;
    logic               accept_s;

    logic [6:0]         word_idx_r;
    logic [4:0]         bit_sel_r;
    logic [1:0]         lat_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;

    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               bram_en_r;
    logic               bram_we_r;
    logic [12:0]        bram_addr_r;
    logic [31:0]        bram_wdata_r;
    logic               icap_start_r;
    logic [31:0]        flip_word_r;
`ifdef FI_VERIFY_EN
    logic [31:0]        rb_data_r;
`endif

    // One-hot bit mask for the selected bit inside the 32-bit frame word.
    function automatic logic [31:0] bit_mask(input logic [4:0] sel);
        bit_mask = 32'h0000_0001 << sel;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && bus.start;

    // State register; a synchronous reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and error detection.
    always_comb begin
        state_nx_s = state_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_CHECK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if ({1'b0, word_idx_r} >= FW_C) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_RD: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_r >= LAT_C) begin
                    state_nx_s = ST_MOD;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_MOD: begin
                state_nx_s = ST_WR;
            end
            ST_WR: begin
`ifdef FI_VERIFY_EN
                state_nx_s = ST_VRD;
`else
                state_nx_s = ST_ICAP;
`endif
            end
`ifdef FI_VERIFY_EN
            ST_VRD: begin
                state_nx_s = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (lat_cnt_r >= LAT_C) begin
                    state_nx_s = ST_VCMP;
                end else begin
                    state_nx_s = ST_VWAIT;
                end
            end
            ST_VCMP: begin
                if (rb_data_r != bram_wdata_r) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_ICAP;
                end
            end
`endif
            ST_ICAP: begin
                state_nx_s = ST_WAIT_ICAP;
            end
            ST_WAIT_ICAP: begin
                // A completion in the final allowed cycle still counts as success.
                if (bus.icap_done) begin
                    state_nx_s = ST_DONE;
                end else if (tmo_cnt_r >= TMO_LAST) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT_ICAP;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request capture plus read-latency and ICAP-timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_r <= 7'd0;
            bit_sel_r  <= 5'd0;
            lat_cnt_r  <= 2'd0;
            tmo_cnt_r  <= '0;
        end else begin
            if (accept_s) begin
                word_idx_r <= bus.bit_location[11:5];
                bit_sel_r  <= bus.bit_location[4:0];
            end else begin
                word_idx_r <= word_idx_r;
                bit_sel_r  <= bit_sel_r;
            end
            if ((state_nx_s == ST_WAIT) || (state_nx_s == ST_VWAIT)) begin
                lat_cnt_r <= (state_r == state_nx_s) ? (lat_cnt_r + 2'd1) : 2'd1;
            end else begin
                lat_cnt_r <= 2'd0;
            end
            // Counts cycles elapsed since the icap_start cycle.
            if (state_nx_s == ST_WAIT_ICAP) begin
                tmo_cnt_r <= (state_r == ST_WAIT_ICAP) ? (tmo_cnt_r + TMO_ONE) : TMO_ONE;
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    // Data path: modified word is captured as the read latency expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_wdata_r <= 32'h0000_0000;
            flip_word_r  <= 32'h0000_0000;
        end else if ((state_r == ST_WAIT) && (state_nx_s == ST_MOD)) begin
            bram_wdata_r <= bus.bram_rdata ^ bit_mask(bit_sel_r);
            flip_word_r  <= bus.bram_rdata ^ bit_mask(bit_sel_r);
        end else begin
            bram_wdata_r <= bram_wdata_r;
            flip_word_r  <= flip_word_r;
        end
    end

`ifdef FI_VERIFY_EN
    // Readback capture for the post-write comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_data_r <= 32'h0000_0000;
        end else if ((state_r == ST_VWAIT) && (state_nx_s == ST_VCMP)) begin
            rb_data_r <= bus.bram_rdata;
        end else begin
            rb_data_r <= rb_data_r;
        end
    end
`endif

    // Registered strobes and status decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            bram_en_r    <= 1'b0;
            bram_we_r    <= 1'b0;
            bram_addr_r  <= 13'd0;
            icap_start_r <= 1'b0;
        end else begin
            busy_r       <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
            done_r       <= (state_nx_s == ST_DONE);
            bram_en_r    <= (state_nx_s == ST_RD) || (state_nx_s == ST_WR) ||
                            (state_nx_s == ST_VRD);
            bram_we_r    <= (state_nx_s == ST_WR);
            icap_start_r <= (state_nx_s == ST_ICAP);
            if (state_nx_s == ST_RD) begin
                bram_addr_r <= BASE_C + {6'd0, word_idx_r};
            end else begin
                bram_addr_r <= bram_addr_r;
            end
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.bram_en    = bram_en_r;
    assign bus.bram_we    = bram_we_r;
    assign bus.bram_addr  = bram_addr_r;
    assign bus.bram_wdata = bram_wdata_r;
    assign bus.icap_start = icap_start_r;
    assign bus.flip_word  = flip_word_r;

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// Randomized self-checking bench for fault_inject_ctrl with a timeline-based reference
// model, a BRAM model with exact read latency and an ICAP completion responder.
module tb_fault_inject_ctrl;
    localparam int BASE = 105;
    localparam int FW   = 101;
    localparam int L    = 1;
    localparam int TMO  = 40;
`ifdef FI_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam logic [31:0] CORRUPT = 32'h8000_0000;

    logic clk;
    logic rst;
    fault_inject_if bus();

    fault_inject_ctrl #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .RD_LAT(L), .ICAP_TMO(TMO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem     [0:8191];
    logic [31:0] ref_mem [0:8191];
    int          rq_due[$];
    logic [31:0] rq_data[$];

    // reference model state
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_word, m_bit, m_n, m_done_off, m_icap_off;
    bit          m_corrupt, m_chk_err;
    logic [31:0] m_addr, m_wdata, m_flip;
    bit          m_err;

    // observations within the current request
    int obs_we, obs_icap, obs_icap_cyc, obs_done_cyc;

    // driver state
    int req_n = 0;
    bit req_corrupt = 1'b0;
    bit corrupt_wr = 1'b0;
    bit in_req = 1'b0;
    int drv_t0 = 0, drv_done_off = 0, drv_icap_off = 0;
    bit drv_has_icap = 1'b0;

    function automatic int icap_off_f();
        return 5 + L + (VERIFY ? (2 + L) : 0);
    endfunction

    function automatic bit has_icap_f(input int bitloc, input bit corrupt);
        return ((bitloc / 32) < FW) && !(VERIFY && corrupt);
    endfunction

    function automatic int done_off_f(input int bitloc, input int n, input bit corrupt);
        if ((bitloc / 32) >= FW) return 2;
        if (VERIFY && corrupt) return 7 + 2 * L;
        if (n == 0) return icap_off_f() + TMO;
        return icap_off_f() + 1 + n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Model update at the active edge, using the inputs the DUT samples there.
    task automatic model_step();
        int dp, dn;
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_addr = 32'd0; m_wdata = 32'd0; m_flip = 32'd0; m_err = 1'b0;
        end else begin
            dp = cyc - 1 - m_t0;
            if (bus.start && !(m_active && dp >= 1 && dp <= m_done_off)) begin
                m_active   = 1'b1;
                m_t0       = cyc - 1;
                m_word     = int'(bus.bit_location) / 32;
                m_bit      = int'(bus.bit_location) % 32;
                m_n        = req_n;
                m_corrupt  = req_corrupt;
                m_chk_err  = (m_word >= FW);
                m_done_off = done_off_f(int'(bus.bit_location), req_n, req_corrupt);
                m_icap_off = icap_off_f();
                m_err      = 1'b0;
            end
            if (m_active) begin
                dn = cyc - m_t0;
                if (!m_chk_err) begin
                    if (dn == 2) m_addr = BASE + m_word;
                    if (dn == 3 + L) begin
                        m_wdata = ref_mem[BASE + m_word] ^ (32'h1 << m_bit);
                        m_flip  = m_wdata;
                    end
                    if (dn == 4 + L)
                        ref_mem[BASE + m_word] = m_wdata ^ (m_corrupt ? CORRUPT : 32'h0);
                end
                if (dn == m_done_off)
                    m_err = m_chk_err || (m_n == 0) || (VERIFY && m_corrupt);
            end
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    task automatic compare();
        int d;
        bit inseq, ok;
        d     = cyc - m_t0;
        inseq = m_active && d >= 1 && d <= m_done_off;
        ok    = inseq && !m_chk_err;
        chk("busy", bus.busy, 32'(inseq && d < m_done_off));
        chk("done", bus.done, 32'(inseq && d == m_done_off));
        chk("err", bus.err, 32'(m_err));
        chk("bram_en", bus.bram_en, 32'(ok && (d == 2 || d == 4 + L || (VERIFY && d == 5 + L))));
        chk("bram_we", bus.bram_we, 32'(ok && d == 4 + L));
        chk("icap_start", bus.icap_start, 32'(ok && !(VERIFY && m_corrupt) && d == m_icap_off));
        chk("bram_addr", 32'(bus.bram_addr), m_addr);
        chk("bram_wdata", bus.bram_wdata, m_wdata);
        chk("flip_word", bus.flip_word, m_flip);
        if (inseq && d == 1) begin
            obs_we = 0; obs_icap = 0; obs_icap_cyc = -1; obs_done_cyc = -1;
        end
        if (inseq) begin
            if (bus.bram_we === 1'b1) obs_we++;
            if (bus.icap_start === 1'b1) begin obs_icap++; obs_icap_cyc = cyc; end
            if (bus.done === 1'b1) obs_done_cyc = cyc;
        end
    endtask

    // BRAM model: accepts the port request of the current cycle.
    task automatic env_sample();
        if (bus.bram_en === 1'b1) begin
            if (bus.bram_we === 1'b1) begin
                mem[bus.bram_addr] = bus.bram_wdata ^ (corrupt_wr ? CORRUPT : 32'h0);
            end else begin
                rq_due.push_back(cyc + L);
                rq_data.push_back(mem[bus.bram_addr]);
            end
        end
    endtask

    // Read data is valid only in the cycle exactly L cycles after the enable cycle.
    task automatic drive_rdata();
        while (rq_due.size() > 0 && rq_due[0] < cyc) begin
            void'(rq_due.pop_front());
            void'(rq_data.pop_front());
        end
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            void'(rq_due.pop_front());
            bus.bram_rdata = rq_data.pop_front();
        end else begin
            bus.bram_rdata = $urandom;
        end
    endtask

    // ICAP responder plus stray completion pulses outside the wait window.
    task automatic respond();
        int d;
        bit window;
        d      = cyc - drv_t0;
        window = in_req && drv_has_icap && d > drv_icap_off && d < drv_done_off;
        if (in_req && drv_has_icap && req_n > 0 && d == drv_icap_off + req_n)
            bus.icap_done = 1'b1;
        else if (!window && $urandom_range(0, 7) == 0)
            bus.icap_done = 1'b1;
        else
            bus.icap_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        drive_rdata();
        @(negedge clk);
        compare();
        env_sample();
        respond();
    endtask

    task automatic run_req(input int bitloc, input int n, input bit corrupt,
                           input int extra_d, input int abort_d);
        bus.bit_location = 12'(bitloc);
        req_n        = n;
        req_corrupt  = corrupt;
        corrupt_wr   = corrupt;
        drv_t0       = cyc;
        drv_done_off = done_off_f(bitloc, n, corrupt);
        drv_icap_off = icap_off_f();
        drv_has_icap = has_icap_f(bitloc, corrupt);
        in_req       = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int i = 1; i <= drv_done_off; i++) begin
            if (i == extra_d) bus.start = 1'b1;
            if (i == abort_d) rst = 1'b1;
            tick();
            bus.start = 1'b0;
            if (i == abort_d) begin
                rst = 1'b0;
                break;
            end
        end
        in_req     = 1'b0;
        corrupt_wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bit_location = 12'd0;
        bus.icap_done = 1'b0;
        bus.bram_rdata = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", bus.busy, 32'd0);
        chk("reset_done", bus.done, 32'd0);
        chk("reset_err", bus.err, 32'd0);
        chk("reset_flip", bus.flip_word, 32'd0);
        chk("reset_addr", 32'(bus.bram_addr), 32'd0);

        // bit 0 of word 0
        mem[105] = 32'h0; ref_mem[105] = 32'h0;
        run_req(0, 3, 1'b0, 0, 0);
        chk("t1_mem105", mem[105], 32'h0000_0001);
        chk("t1_flip", bus.flip_word, 32'h0000_0001);
        chk("t1_err", bus.err, 32'd0);
        chk("t1_we_cnt", 32'(obs_we), 32'd1);
        chk("t1_icap_cnt", 32'(obs_icap), 32'd1);
        chk("t1_latency", 32'(obs_done_cyc - drv_t0), VERIFY ? 32'd13 : 32'd10);

        // word 3 bit 4
        mem[108] = 32'hFFFF_FFFF; ref_mem[108] = 32'hFFFF_FFFF;
        run_req(100, 5, 1'b0, 0, 0);
        chk("t2_mem108", mem[108], 32'hFFFF_FFEF);
        chk("t2_latency", 32'(obs_done_cyc - drv_t0), VERIFY ? 32'd15 : 32'd12);

        // word 101 out of range
        run_req(3232, 2, 1'b0, 0, 0);
        chk("t3_err", bus.err, 32'd1);
        chk("t3_we_cnt", 32'(obs_we), 32'd0);
        chk("t3_icap_cnt", 32'(obs_icap), 32'd0);
        chk("t3_latency", 32'(obs_done_cyc - drv_t0), 32'd2);

        // last valid bit, latest successful completion
        run_req(3231, TMO - 1, 1'b0, 0, 0);
        chk("t3b_err", bus.err, 32'd0);

        // ICAP never completes
        run_req(1234, 0, 1'b0, 0, 0);
        chk("t4_err", bus.err, 32'd1);
        chk("t4_tmo", 32'(obs_done_cyc - obs_icap_cyc), 32'(TMO));
        chk("t4_icap_cnt", 32'(obs_icap), 32'd1);

        // restart while busy, then reset in WAIT_ICAP, then start together with reset
        run_req(200, 0, 1'b0, 3, icap_off_f() + 3);
        tick();
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("t5_busy", bus.busy, 32'd0);
        chk("t5_err", bus.err, 32'd0);
        chk("t5_flip", bus.flip_word, 32'd0);
        chk("t5_wdata", bus.bram_wdata, 32'd0);
        run_req(64, 2, 1'b0, 0, 0);
        chk("t5_after_err", bus.err, 32'd0);
        chk("t5_after_we", 32'(obs_we), 32'd1);

`ifdef FI_VERIFY_EN
        run_req(50, 2, 1'b1, 0, 0);
        chk("t6_err", bus.err, 32'd1);
        chk("t6_icap_cnt", 32'(obs_icap), 32'd0);
`endif

        for (int r = 0; r < 40; r++) begin
            int bl, n, doff, ex, ab;
            bl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3232, 4095))
                                             : int'($urandom_range(0, 3231));
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = TMO - 1;
                default: n = int'($urandom_range(1, 12));
            endcase
            doff = done_off_f(bl, n, 1'b0);
            ex   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, doff)) : 0;
            ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, doff - 1)) : 0;
            if (ab == ex) ex = 0;
            run_req(bl, n, 1'b0, ex, ab);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
